// File: rtl/shared_adder_arbiter.sv
// Two requesters share one carry-increment adder through a round-robin grant
// and a single-entry result register that sustains one operation per cycle.

module cia_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  localparam int H = N / 2;

  logic [H:0]   lo;
  logic [H:0]   hi0;
  logic [H-1:0] hi_inc;

  // Upper half is summed assuming no carry-in, then incremented if the lower half carries.
  assign lo     = {1'b0, a_i[H-1:0]} + {1'b0, b_i[H-1:0]} + {{H{1'b0}}, cin_i};
  assign hi0    = {1'b0, a_i[N-1:H]} + {1'b0, b_i[N-1:H]};
  assign hi_inc = hi0[H-1:0] + {{(H-1){1'b0}}, 1'b1};

  assign sum_o  = {(lo[H] ? hi_inc : hi0[H-1:0]), lo[H-1:0]};
  assign cout_o = hi0[H] | (lo[H] & (&hi0[H-1:0]));
endmodule

// state | meaning
// EMPTY | result register holds nothing to deliver
// FULL  | result register holds an undelivered result
module shared_adder_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_in1,
  input  logic [N-1:0] req0_in2,
  input  logic         req0_cin,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_in1,
  input  logic [N-1:0] req1_in2,
  input  logic         req1_cin,
  output logic         req1_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_sum,
  output logic         res_cout,
  output logic         res_id
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e       state_q;
  logic         prio_q;
  logic [N-1:0] res_sum_q;
  logic         res_cout_q;
  logic         res_id_q;

  logic         slot_free;
  logic         gnt0;
  logic         gnt1;
  logic         grant;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_sum;
  logic         add_cout;

  assign slot_free = (state_q == EMPTY) | res_ready;

  // rst_n gates the grant so nothing is accepted while reset is held.
  assign gnt0  = rst_n & slot_free & req0_valid & (~req1_valid | ~prio_q);
  assign gnt1  = rst_n & slot_free & req1_valid & (~req0_valid |  prio_q);
  assign grant = gnt0 | gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign add_a   = gnt1 ? req1_in1 : req0_in1;
  assign add_b   = gnt1 ? req1_in2 : req0_in2;
  assign add_cin = gnt1 ? req1_cin : req0_cin;

  cia_adder #(.N(N)) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      prio_q     <= 1'b0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_id_q   <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (grant) state_q <= FULL;
        FULL:  if (res_ready && !grant) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (grant) begin
        res_sum_q  <= add_sum;
        res_cout_q <= add_cout;
        res_id_q   <= gnt1;
        prio_q     <= ~gnt1;
      end
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Bench for shared_adder_arbiter: directed vector table, hand-written
// stall/reset sequences and a randomized run against a queue-based model.

module tb_shared_adder_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_cin, req1_cin;
  logic [N-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_ready, res_cout, res_id;
  logic [N-1:0] res_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shared_adder_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id)
  );

  typedef struct {
    logic        v0, v1;
    logic [31:0] a0, b0;
    logic        c0;
    logic [31:0] a1, b1;
    logic        c1;
    logic        rr;
    logic        e_r0, e_r1, e_v;
    logic [31:0] e_sum;
    logic        e_cout, e_id;
  } vec_t;

  vec_t vecs[8];

  // Randomized-run model: slot occupancy, priority, and ordered scoreboard of {id,cout,sum}.
  logic        m_full, m_prio;
  logic [33:0] sb[$];
  int          pushed[2];
  int          popped[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic c0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic c1,
                       input logic rr);
    req0_valid = v0; req0_in1 = a0; req0_in2 = b0; req0_cin = c0;
    req1_valid = v1; req1_in1 = a1; req1_in2 = b1; req1_cin = c1;
    res_ready  = rr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 32'd1, 32'd2, 1'b0, 1'b1, 32'd3, 32'd4, 1'b0, 1'b1);
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", {res_cout, res_id, res_sum}, 0);
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    m_full = 1'b0;
    m_prio = 1'b0;
  endtask

  task automatic rand_cycle(input bit idle);
    logic        v0, v1, c0, c1, rr, free, gv;
    logic [31:0] a0, b0, a1, b1;
    logic        gid;
    logic [32:0] full_sum;
    logic [33:0] exp;
    @(negedge clk);
    v0 = idle ? 1'b0 : 1'($urandom_range(0, 1));
    v1 = idle ? 1'b0 : 1'($urandom_range(0, 1));
    a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    b0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    a1 = ($urandom_range(0, 7) == 0) ? 32'h0000_FFFF : $urandom;
    b1 = $urandom;
    c0 = 1'($urandom_range(0, 1));
    c1 = 1'($urandom_range(0, 1));
    rr = idle ? 1'b1 : ($urandom_range(0, 3) != 0);
    drive(v0, a0, b0, c0, v1, a1, b1, c1, rr);
    #1;
    free = !m_full || rr;
    gv   = free && (v0 || v1);
    gid  = (v0 && v1) ? m_prio : v1;
    chk("rand_ready0", req0_ready, gv && !gid);
    chk("rand_ready1", req1_ready, gv && gid);
    chk("rand_valid", res_valid, m_full);
    if (m_full && rr) begin
      if (sb.size() == 0) begin
        chk("rand_sb_underflow", 1, 0);
      end else begin
        exp = sb.pop_front();
        chk("rand_result", {res_id, res_cout, res_sum}, exp);
        popped[exp[33]]++;
      end
    end
    if (gv) begin
      full_sum = gid ? ({1'b0, a1} + {1'b0, b1} + 33'(c1)) : ({1'b0, a0} + {1'b0, b0} + 33'(c0));
      sb.push_back({gid, full_sum});
      pushed[gid]++;
    end
    @(posedge clk);
    if (gv) begin
      m_full = 1'b1;
      m_prio = ~gid;
    end else if (rr) begin
      m_full = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{1, 0, 32'h5, 32'h3, 1, 32'h0, 32'h0, 0, 1,  1, 0, 1, 32'h0000_0009, 0, 0};
    vecs[1] = '{0, 1, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1,  0, 1, 1, 32'hFFFF_FFFF, 1, 1};
    vecs[2] = '{1, 0, 32'h0000_FFFF, 32'h1, 0, 32'h0, 32'h0, 0, 1,  1, 0, 1, 32'h0001_0000, 0, 0};
    vecs[3] = '{1, 1, 32'h1, 32'h1, 0, 32'h8000_0000, 32'h8000_0000, 0, 1,  0, 1, 1, 32'h0, 1, 1};
    vecs[4] = '{1, 1, 32'h2, 32'h2, 0, 32'h7, 32'h7, 0, 0,  0, 0, 1, 32'h0, 1, 1};
    vecs[5] = '{0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 1,  0, 0, 0, 32'h0, 0, 0};
    vecs[6] = '{1, 1, 32'h1234_5678, 32'h1111_1111, 0, 32'h9, 32'h9, 0, 0,  1, 0, 1, 32'h2345_6789, 0, 0};
    vecs[7] = '{1, 1, 32'h3, 32'h3, 0, 32'hFFFF_FFFF, 32'h0, 1, 1,  0, 1, 1, 32'h0, 1, 1};

    rst_n = 1'b1;
    pushed = '{0, 0};
    popped = '{0, 0};
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    do_reset();

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].c0,
            vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].c1, vecs[i].rr);
      #1;
      chk($sformatf("vec%0d_ready0", i), req0_ready, vecs[i].e_r0);
      chk($sformatf("vec%0d_ready1", i), req1_ready, vecs[i].e_r1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), res_valid, vecs[i].e_v);
      if (vecs[i].e_v)
        chk($sformatf("vec%0d_result", i), {res_id, res_cout, res_sum},
            {vecs[i].e_id, vecs[i].e_cout, vecs[i].e_sum});
    end

    // Both requesters continuously valid: strict alternation starting at 0.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 32'd10 + 32'(k), 32'd1, 1'b0, 1'b1, 32'd100 + 32'(k), 32'd1, 1'b0, 1'b1);
      #1;
      chk($sformatf("alt%0d_ready0", k), req0_ready, (k % 2) == 0);
      chk($sformatf("alt%0d_ready1", k), req1_ready, (k % 2) == 1);
      @(posedge clk);
      #1;
      chk($sformatf("alt%0d_id", k), res_id, k % 2);
      chk($sformatf("alt%0d_sum", k), res_sum, ((k % 2) ? 32'd101 : 32'd11) + 32'(k));
    end

    // Consumer stall holds the result and blocks both requesters.
    do_reset();
    @(negedge clk);
    drive(1'b1, 32'd7, 32'd8, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b1, 32'd100, 32'd200, 1'b1, 1'b0);
      #1;
      chk("stall_readies", {req0_ready, req1_ready}, 0);
      chk("stall_result", {res_valid, res_id, res_cout, res_sum}, {1'b1, 1'b0, 1'b0, 32'd15});
      @(posedge clk);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    chk("unstall_readies", {req0_ready, req1_ready}, 2'b01);
    @(posedge clk);
    #1;
    chk("unstall_result", {res_valid, res_id, res_cout, res_sum}, {1'b1, 1'b1, 1'b0, 32'd301});

    // Asynchronous reset while full discards the result without a clock edge.
    @(negedge clk);
    res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", res_valid, 0);
    chk("async_rst_readies", {req0_ready, req1_ready}, 0);
    chk("async_rst_sum", {res_id, res_cout, res_sum}, 0);
    @(posedge clk);
    #1;
    chk("rst_held_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'd20, 32'd22, 1'b1, 1'b1, 32'd5, 32'd5, 1'b0, 1'b1);
    #1;
    chk("post_rst_readies", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1;
    chk("post_rst_result", {res_valid, res_id, res_sum}, {1'b1, 1'b0, 32'd43});

    do_reset();
    sb.delete();
    for (int c = 0; c < 10000; c++) rand_cycle(1'b0);
    rand_cycle(1'b1);
    rand_cycle(1'b1);
    chk("sb_drained", sb.size(), 0);
    chk("id0_count", popped[0], pushed[0]);
    chk("id1_count", popped[1], pushed[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shared_adder_arbiter.md
SHARED_ADDER_ARBITER -- requirements
Module: shared_adder_arbiter

Interface
REQ-001 Parameter: N, default 32, operand and sum width in bits; SHALL support any even N >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 holds a valid operation.
REQ-005 req0_in1, req0_in2  input  N each  requester 0 operands.
REQ-006 req0_cin  input  1  requester 0 carry-in.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_in1, req1_in2, req1_cin, req1_ready  same widths and meaning as REQ-004..REQ-007, for requester 1.
REQ-009 res_valid  output  1  result register holds an undelivered result.
REQ-010 res_ready  input  1  consumer accepts the result this cycle.
REQ-011 res_sum  output  N  registered sum.
REQ-012 res_cout  output  1  registered carry-out.
REQ-013 res_id  output  1  ID of the requester that owns the result (0 or 1).

Function
REQ-014 The block SHALL contain exactly one N-bit carry-increment adder instance, shared by both requesters.
REQ-015 Transfer rule: a transfer on any port SHALL occur only on a cycle where valid and ready are both 1.
REQ-016 slot_free = !res_valid | res_ready; the block SHALL grant at most one requester per cycle, and only when slot_free is 1.
REQ-017 The block SHALL have a one-bit round-robin pointer prio; when both valid, grant req[prio]; when one valid, grant that one.
REQ-018 On every grant, prio SHALL become the complement of the granted ID; prio SHALL be unchanged when no grant occurs.
REQ-019 reqX_ready SHALL be combinational: 1 only for the granted requester, 0 otherwise; ready SHALL NOT depend on the other requester's ready.
REQ-020 Adder inputs SHALL be muxed from the granted requester; on grant, {res_cout,res_sum} = in1+in2+cin (N+1 bits, no truncation of carry) and res_id SHALL be captured at the next edge.
REQ-021 Latency: a result SHALL be visible with res_valid=1 one cycle after acceptance.
REQ-022 Two-state FSM: EMPTY (res_valid=0) and FULL (res_valid=1). EMPTY->FULL on grant; FULL->EMPTY on res_ready with no grant; FULL->FULL on res_ready with grant (back-to-back, full throughput: one op per cycle); FULL with res_ready=0 SHALL hold.
REQ-023 While FULL and res_ready=0, res_sum, res_cout, res_id SHALL remain stable and both reqX_ready SHALL be 0.
REQ-024 A requester that deasserts valid before acceptance SHALL NOT be granted; no operation SHALL be lost or duplicated.
REQ-025 Wrap-around: all-ones + all-ones + cin=1 SHALL yield res_sum = all-ones, res_cout=1.

Reset
REQ-026 While rst_n=0: res_valid=0, res_sum=0, res_cout=0, res_id=0, prio=0, FSM=EMPTY, req0_ready=req1_ready=0.
REQ-027 Reset assertion mid-operation SHALL immediately discard any held result; first grant after release SHALL use prio=0.
REQ-028 Deassertion SHALL take effect at the first rising clk edge after rst_n goes high; no grant SHALL occur while rst_n=0.

Verification
REQ-029 Reset, req0 only: in1=0x0000_0005, in2=0x0000_0003, cin=1, res_ready=1 -> next cycle res_valid=1, res_sum=0x0000_0009, res_cout=0, res_id=0.
REQ-030 Both valid continuously, res_ready=1, after reset -> res_id sequence 0,1,0,1 on consecutive cycles; each requester ready every other cycle.
REQ-031 N=32, in1=in2=0xFFFF_FFFF, cin=1 -> res_sum=0xFFFF_FFFF, res_cout=1; in1=0x0000_FFFF, in2=1, cin=0 -> res_sum=0x0001_0000 (carry crosses half boundary).
REQ-032 res_ready=0 for 5 cycles with result held and both requesters valid -> res_* stable, both ready=0; res_ready=1 -> result delivered and next grant same cycle.
REQ-033 rst_n pulsed low while FULL and both valid -> res_valid drops to 0 without clock; after release first result has res_id=0.
REQ-034 Randomized: 10k cycles, random valid/res_ready, scoreboard per ID -> every accepted op delivered once, in grant order, sum matches in1+in2+cin.
